muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer: one shift-add or restoring
// shift-subtract step per cycle, with sign fix-up and a registered result.
//
// state | meaning
// IDLE  | waiting for Start_i; divide-by-zero/overflow resolved here directly
// CALC  | one iteration per cycle on magnitudes, down-counter from DATA_WIDTH
// SIGN  | apply sign correction, register selected field into Result_o
// DONE  | Done_o pulse for one cycle, then back to IDLE
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Start_i,
    input  logic [2:0]            Op_i,
    input  logic [DATA_WIDTH-1:0] SrcA_i,
    input  logic [DATA_WIDTH-1:0] SrcB_i,
    input  logic                  Flush_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] Result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [W-1:0]    opnd_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_a_q, neg_ab_q;
    logic [W-1:0]    result_q;

    logic            a_signed, b_signed, a_sgn, b_sgn;
    logic [W-1:0]    a_mag, b_mag;
    logic            is_div_in, div_zero, div_ovf, bypass;
    logic [W-1:0]    bypass_res;
    logic            start_ok;
    logic [W:0]      mul_sum, rem_shift, diff;
    logic [2*W-1:0]  acc_iter, prod;
    logic [W-1:0]    quo_raw, rem_raw, quo, rem, sign_res;

    // Operand classification and the two cases that skip iteration entirely
    always_comb begin
        a_signed   = Op_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        b_signed   = Op_i inside {3'b000, 3'b001, 3'b100, 3'b110};
        a_sgn      = a_signed & SrcA_i[W-1];
        b_sgn      = b_signed & SrcB_i[W-1];
        a_mag      = a_sgn ? -SrcA_i : SrcA_i;
        b_mag      = b_sgn ? -SrcB_i : SrcB_i;
        is_div_in  = Op_i[2];
        div_zero   = is_div_in && (SrcB_i == '0);
        div_ovf    = is_div_in && !Op_i[0] && (SrcA_i == {1'b1, {(W-1){1'b0}}}) && (&SrcB_i);
        bypass     = div_zero || div_ovf;
        bypass_res = '0;
        if (div_zero) bypass_res = Op_i[1] ? SrcA_i : '1;
        else          bypass_res = Op_i[1] ? '0 : SrcA_i;
        start_ok   = (state_q == S_IDLE) && Start_i && !Flush_i;
    end

    // acc_q holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = acc_q[2*W-1:W-1];
        diff      = rem_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (diff[W]) acc_iter = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
            else         acc_iter = {diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_iter = {mul_sum, acc_q[W-1:1]};
        end
        prod    = neg_ab_q ? -acc_q : acc_q;
        quo_raw = acc_q[W-1:0];
        rem_raw = acc_q[2*W-1:W];
        quo     = neg_ab_q ? -quo_raw : quo_raw;
        rem     = neg_a_q ? -rem_raw : rem_raw;
        case (op_q)
            3'b000:                 sign_res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: sign_res = prod[2*W-1:W];
            3'b100, 3'b101:         sign_res = quo;
            default:                sign_res = rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Busy_o  = 1'b0;
        Done_o  = 1'b0;
        case (state_q)
            S_IDLE: if (start_ok) state_d = bypass ? S_DONE : S_CALC;
            S_CALC: begin
                Busy_o = 1'b1;
                if (cnt_q == CW'(1)) state_d = S_SIGN;
            end
            S_SIGN: begin
                Busy_o  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                Done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A flush landing on the DONE cycle still swallows the pulse
        if (Flush_i) begin
            state_d = S_IDLE;
            Done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_ab_q <= 1'b0;
            result_q <= '0;
        end else if (start_ok) begin
            if (bypass) begin
                result_q <= bypass_res;
            end else begin
                op_q     <= Op_i;
                opnd_q   <= is_div_in ? b_mag : a_mag;
                acc_q    <= {{W{1'b0}}, (is_div_in ? a_mag : b_mag)};
                cnt_q    <= CW'(W);
                neg_a_q  <= a_sgn;
                neg_ab_q <= a_sgn ^ b_sgn;
            end
        end else if (!Flush_i && state_q == S_CALC) begin
            acc_q <= acc_iter;
            cnt_q <= cnt_q - CW'(1);
        end else if (!Flush_i && state_q == S_SIGN) begin
            result_q <= sign_res;
        end
    end

    assign Result_o = result_q;

endmodule
